pulse_scan_ctrl: RTL and testbench
==================================

Name:
pulse_scan_ctrl

Overview:
Measurement sequencer for the multi-channel pulse-counter array. Each measurement runs as follows:
- Clears the counters.
- Opens a counting gate of programmable length by driving the array's shared enable.
- Waits a settle interval.
- Snapshots all channel counts.
- Streams the counts out one channel per beat over a valid/ready interface.

It sits between the counter array and a host or readout path. It provides the only enable/clear control of the array.

Parameters:
CH_NUM, 16, number of counter channels (2..64)
CNT_W, 16, width of each channel count
GATE_W, 24, width of gate-length register
SETTLE_CYC, 2, idle cycles between gate close and snapshot (>=1); covers counter edge-detect pipeline

Ports:
i_clk  in  1  clock; single clock domain
i_rst_n  in  1  reset, synchronous, active-low
i_start  in  1  start one measurement; sampled only in IDLE
i_abort  in  1  abort current measurement
i_gate_len  in  GATE_W  gate length in cycles; sampled on accepted i_start
i_cnt_flat  in  CH_NUM*CNT_W  counter outputs; channel k at bits [k*CNT_W +: CNT_W]
o_cnt_en  out  1  enable to counter array
o_cnt_clr  out  1  one-cycle clear to counter array
o_data  out  CNT_W  streamed count
o_ch  out  $clog2(CH_NUM)  channel index of o_data
o_valid  out  1  stream valid
i_ready  in  1  stream ready
o_last  out  1  marks final beat of a scan
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - All outputs go to 0, FSM goes to IDLE, and the shadow registers and counters are cleared.
- Every output is registered.
- FSM states: IDLE -> CLEAR -> GATE -> SETTLE -> SNAP -> SEND -> DONE -> IDLE.
- IDLE:
  - i_start=1 latches i_gate_len and moves to CLEAR.
  - i_start is ignored in every other state.
- CLEAR:
  - Lasts exactly 1 cycle with o_cnt_clr=1.
  - Next state is GATE, or SETTLE if the latched gate length is 0.
- GATE:
  - o_cnt_en=1 for exactly gate_len consecutive cycles.
  - The gate counter counts down from gate_len to 1 and does not wrap.
  - Maximum gate is 2^GATE_W-1 cycles.
- SETTLE:
  - Lasts SETTLE_CYC cycles with o_cnt_en=0.
- SNAP:
  - Lasts 1 cycle.
  - Copies all CH_NUM counts from i_cnt_flat into the shadow registers.
  - The stream reads only the shadow, so later counter activity does not affect the scan.
- SEND:
  - o_valid=1 starting the cycle after SNAP, with o_ch=0 first and incrementing by 1 per accepted beat.
  - A beat transfers when o_valid&&i_ready.
  - While o_valid&&!i_ready, o_data, o_ch and o_last hold stable.
  - With i_ready held at 1, the scan takes CH_NUM back-to-back cycles.
  - o_last=1 on the beat of channel CH_NUM-1.
  - The cycle after the last transfer: o_valid=0 and state goes to DONE.
- DONE:
  - Lasts 1 cycle with o_done=1, then returns to IDLE (o_busy=0 the following cycle).
- Latency, with i_start accepted at cycle 0 and gate_len=N:
  - o_cnt_clr=1 in cycle 1.
  - o_cnt_en=1 in cycles 2..N+1.
  - SNAP in cycle N+2+SETTLE_CYC.
  - First o_valid in cycle N+3+SETTLE_CYC.
- i_abort:
  - In any non-IDLE state, the FSM goes to IDLE on the next edge.
  - o_cnt_en, o_valid and o_last drop that same edge; o_done is not pulsed.
  - Abort takes priority over a pending transfer in the same cycle; that beat is not counted as delivered.
  - i_abort in IDLE has no effect.
- Reset during any state behaves the same as abort, and additionally clears the shadow registers.
- i_start and i_abort both high in IDLE: start is accepted, then abort takes effect the next cycle.

Optional Feature:
PULSE_SCAN_MASK_EN.
- Defined:
  - Adds input i_ch_mask [CH_NUM-1:0], latched with i_gate_len on start.
  - SEND emits only channels whose mask bit is 1, in ascending order; o_ch carries the true channel index.
  - o_last marks the highest enabled channel.
  - An all-zero mask goes SNAP -> DONE with no beats.
  - Skipped channels cost no cycles.
- Undefined:
  - No i_ch_mask port; all channels are always sent.

Test Plan:
- gate_len=10, 3 pulses on ch0 and 7 on ch5 inside the gate, i_ready=1 -> o_cnt_en high exactly 10 cycles; 16 beats; ch0=3, ch5=7, all others 0; o_last on ch15; o_done 1 cycle.
- Same stimulus with i_ready toggling 1/0 every cycle -> 16 beats, data stable while stalled, no duplicated or skipped channel.
- gate_len=0 -> o_cnt_en never asserted; CLEAR goes to SETTLE; 16 beats all 0.
- Pulses continue after the gate closes -> streamed counts equal the in-gate values only.
- i_abort asserted at the ch4 beat -> o_valid low the next cycle, no o_done, o_busy low; a new i_start then runs a full clean scan.
- i_start pulsed during GATE -> ignored, gate length unchanged. With PULSE_SCAN_MASK_EN, mask=16'h0021 -> beats for ch0 and ch5 only, o_last on ch5; mask=0 -> no beats, o_done still pulses.

Source files
------------

// File: rtl/pulse_scan_ctrl.sv
// pulse_scan_ctrl: measurement sequencer for the pulse-counter array.
// Each run clears the counters, opens the gate, waits for the counter
// pipeline to settle, snapshots every channel and streams the snapshot
// out one channel per valid/ready beat.
// Optional build macro PULSE_SCAN_MASK_EN adds i_ch_mask. Channels whose
// mask bit is 0 are skipped without costing any cycles.
module pulse_scan_ctrl #(
  parameter int CH_NUM     = 16,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 24,
  parameter int SETTLE_CYC = 2,
  localparam int CW        = $clog2(CH_NUM)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [GATE_W-1:0]       i_gate_len,
`ifdef PULSE_SCAN_MASK_EN
  input  logic [CH_NUM-1:0]       i_ch_mask,
`endif
  input  logic [CH_NUM*CNT_W-1:0] i_cnt_flat,
  output logic                    o_cnt_en,
  output logic                    o_cnt_clr,
  output logic [CNT_W-1:0]        o_data,
  output logic [CW-1:0]           o_ch,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_SNAP, S_SEND, S_DONE
  } state_t;

  state_t                         state, nxt;
  logic [GATE_W-1:0]              glen_q, gcnt, gcnt_d;
  logic [SW-1:0]                  scnt, scnt_d;
  logic [CH_NUM-1:0]              mask_q;
  logic [CH_NUM-1:0][CNT_W-1:0]   shadow, cnt_v;
  logic [CW-1:0]                  ch_d, hi_ch;
  logic [CNT_W-1:0]               data_d;
  logic                           valid_d, last_d;
  logic [CW:0]                    first_pick, next_pick;

  assign cnt_v = i_cnt_flat;

  // Lowest enabled channel at or above 'from'; MSB flags that one exists.
  function automatic logic [CW:0] pick(input logic [CH_NUM-1:0] m, input int from);
    pick = '0;
    for (int k = CH_NUM - 1; k >= 0; k--)
      if (m[k] && k >= from) pick = {1'b1, CW'(k)};
  endfunction

`ifndef PULSE_SCAN_MASK_EN
  assign mask_q = '1;
`endif

  // Channel selection: first, following and highest enabled channel.
  always_comb begin
    first_pick = pick(mask_q, 0);
    next_pick  = pick(mask_q, int'(o_ch) + 1);
    hi_ch      = '0;
    for (int k = 0; k < CH_NUM; k++)
      if (mask_q[k]) hi_ch = CW'(k);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next state, timers and next values of the stream outputs.
  always_comb begin
    nxt     = state;
    gcnt_d  = gcnt;
    scnt_d  = scnt;
    ch_d    = o_ch;
    data_d  = o_data;
    valid_d = o_valid;
    last_d  = o_last;
    case (state)
      S_IDLE:  if (i_start) nxt = S_CLEAR;
      S_CLEAR: begin
        if (glen_q == '0) begin
          nxt    = S_SETTLE;
          scnt_d = SW'(SETTLE_CYC);
        end else begin
          nxt    = S_GATE;
          gcnt_d = glen_q;
        end
      end
      S_GATE: begin
        if (gcnt == GATE_W'(1)) begin
          nxt    = S_SETTLE;
          scnt_d = SW'(SETTLE_CYC);
        end else begin
          gcnt_d = gcnt - GATE_W'(1);
        end
      end
      S_SETTLE: begin
        if (scnt == SW'(1)) nxt = S_SNAP;
        else                scnt_d = scnt - SW'(1);
      end
      S_SNAP: begin
        // Shadow is written this same edge, so the first beat comes
        // straight from the counter inputs.
        if (first_pick[CW]) begin
          nxt     = S_SEND;
          valid_d = 1'b1;
          ch_d    = first_pick[CW-1:0];
          data_d  = cnt_v[ch_d];
          last_d  = (ch_d == hi_ch);
        end else begin
          nxt = S_DONE;
        end
      end
      S_SEND: begin
        if (o_valid && i_ready) begin
          if (o_last) begin
            nxt     = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            ch_d   = next_pick[CW-1:0];
            data_d = shadow[ch_d];
            last_d = (ch_d == hi_ch);
          end
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // Abort wins over any pending transfer.
    if (state != S_IDLE && i_abort) begin
      nxt     = S_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Latched run setup, snapshot, timers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      glen_q    <= '0;
`ifdef PULSE_SCAN_MASK_EN
      mask_q    <= '0;
`endif
      shadow    <= '0;
      gcnt      <= '0;
      scnt      <= '0;
      o_ch      <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_cnt_en  <= 1'b0;
      o_cnt_clr <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      if (state == S_IDLE && i_start) begin
        glen_q <= i_gate_len;
`ifdef PULSE_SCAN_MASK_EN
        mask_q <= i_ch_mask;
`endif
      end
      if (state == S_SNAP) shadow <= cnt_v;
      gcnt      <= gcnt_d;
      scnt      <= scnt_d;
      o_ch      <= ch_d;
      o_data    <= data_d;
      o_valid   <= valid_d;
      o_last    <= last_d;
      o_cnt_en  <= (nxt == S_GATE);
      o_cnt_clr <= (nxt == S_CLEAR);
      o_busy    <= (nxt != S_IDLE);
      o_done    <= (nxt == S_DONE);
    end
  end
endmodule

// File: tb/tb_pulse_scan_ctrl.sv
// tb_pulse_scan_ctrl: runs pulse_scan_ctrl against a behavioural counter
// array. Expected beats are queued when a run is set up and popped when
// the DUT transfers a beat.
module tb_pulse_scan_ctrl;
  localparam int CH = 16;
  localparam int CW = 16;
  localparam int GW = 24;

  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] d;
    logic        l;
  } beat_t;

  logic               i_clk = 1'b0;
  logic               i_rst_n, i_start, i_abort, i_ready;
  logic [GW-1:0]      i_gate_len;
  logic [CH-1:0]      i_ch_mask;
  logic [CH*CW-1:0]   i_cnt_flat;
  logic               o_cnt_en, o_cnt_clr, o_valid, o_last, o_busy, o_done;
  logic [CW-1:0]      o_data;
  logic [3:0]         o_ch;

  logic [CH-1:0][CW-1:0] cnt;
  logic [CH-1:0]      pulse;
  logic               leak;
  beat_t              sb[$];
  int                 total, bad, en_cnt, done_cnt;

  always #5 i_clk = ~i_clk;

  pulse_scan_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_gate_len(i_gate_len),
`ifdef PULSE_SCAN_MASK_EN
    .i_ch_mask(i_ch_mask),
`endif
    .i_cnt_flat(i_cnt_flat), .o_cnt_en(o_cnt_en), .o_cnt_clr(o_cnt_clr),
    .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  // Counter array: clear wins, counts only while enabled (or leaking).
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < CH; k++) begin
      if (o_cnt_clr)            cnt[k] <= '0;
      else if (o_cnt_en || leak) cnt[k] <= cnt[k] + CW'(pulse[k]);
    end
  end
  assign i_cnt_flat = cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: counts enable/done cycles, checks stall stability and beats.
  initial begin
    logic sp, pl;
    logic [3:0] pch;
    logic [15:0] pd;
    beat_t b;
    sp = 1'b0; pl = 1'b0; pch = '0; pd = '0;
    forever begin
      @(negedge i_clk);
      if (o_cnt_en) en_cnt++;
      if (o_done) done_cnt++;
      if (sp) begin
        chk("stall_vld", 32'(o_valid), 32'(1));
        chk("stall_ch", 32'(o_ch), 32'(pch));
        chk("stall_data", 32'(o_data), 32'(pd));
        chk("stall_last", 32'(o_last), 32'(pl));
      end
      if (o_valid && i_ready && !i_abort) begin
        if (sb.size() == 0) chk("extra_beat", 32'(o_ch), 32'hffff_ffff);
        else begin
          b = sb.pop_front();
          chk("beat_ch", 32'(o_ch), 32'(b.ch));
          chk("beat_data", 32'(o_data), 32'(b.d));
          chk("beat_last", 32'(o_last), 32'(b.l));
        end
      end
      sp  = o_valid && !i_ready && !i_abort;
      pch = o_ch; pd = o_data; pl = o_last;
    end
  end

  // One measurement: glen, toggle ready, abort at channel (-1 none),
  // leak counts during SEND, extra start during GATE, channel mask.
  task automatic run(input int glen, input bit tog, input int abort_ch,
                     input bit lk, input bit sig, input logic [CH-1:0] mask);
    int g, c, hi;
    bit fin, first_v;
    beat_t b;
    logic [CH-1:0] m;
`ifdef PULSE_SCAN_MASK_EN
    m = mask;
`else
    m = '1;
`endif
    hi = -1;
    for (int k = 0; k < CH; k++) if (m[k]) hi = k;
    for (int k = 0; k < CH; k++)
      if (m[k] && (abort_ch < 0 || k < abort_ch)) begin
        b.ch = 4'(k);
        b.d  = (k == 0) ? 16'((glen < 3) ? glen : 3) :
               (k == 5) ? 16'((glen < 7) ? glen : 7) : 16'd0;
        b.l  = (k == hi);
        sb.push_back(b);
      end
    en_cnt = 0; done_cnt = 0; g = 0; fin = 0; first_v = 0;
    i_gate_len = GW'(glen); i_ch_mask = mask; i_start = 1'b1;
    tick();
    i_start = 1'b0; c = 1;
    chk("clr_cyc1", 32'(o_cnt_clr), 32'(1));
    chk("busy_cyc1", 32'(o_busy), 32'(1));
    for (int n = 0; n < 300 && !fin; n++) begin
      pulse = '0; leak = 1'b0;
      if (o_cnt_en) begin
        pulse[0] = (g < 3);
        pulse[5] = (g < 7);
        if (sig && g == 4) begin i_start = 1'b1; i_gate_len = GW'(3); end
        g++;
      end
      if (lk && o_valid) begin pulse = '1; leak = 1'b1; end
      if (o_valid && !first_v) begin
        first_v = 1;
        chk("first_valid_cyc", 32'(c), 32'(glen + 5));
      end
      i_ready = tog ? !i_ready : 1'b1;
      if (abort_ch >= 0 && o_valid && int'(o_ch) == abort_ch) i_abort = 1'b1;
      tick(); c++;
      i_start = 1'b0; i_gate_len = GW'(glen);
      if (i_abort) begin
        i_abort = 1'b0;
        chk("abort_vld", 32'(o_valid), 32'(0));
        chk("abort_last", 32'(o_last), 32'(0));
        chk("abort_busy", 32'(o_busy), 32'(0));
        fin = 1;
      end else if (o_done) begin
        chk("done_vld", 32'(o_valid), 32'(0));
        tick();
        chk("done_1cyc", 32'(o_done), 32'(0));
        chk("idle_busy", 32'(o_busy), 32'(0));
        fin = 1;
      end
    end
    pulse = '0; leak = 1'b0; i_ready = 1'b1;
    chk("run_finished", 32'(fin), 32'(1));
    chk("en_cycles", 32'(en_cnt), 32'(glen));
    chk("done_pulses", 32'(done_cnt), 32'(abort_ch < 0));
    chk("beats_left", 32'(sb.size()), 32'(0));
    sb.delete();
    tick();
  endtask

  initial begin
    total = 0; bad = 0; en_cnt = 0; done_cnt = 0;
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b1;
    i_gate_len = '0; i_ch_mask = '1; pulse = '0; leak = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_en", 32'(o_cnt_en), 32'(0));
    chk("rst_clr", 32'(o_cnt_clr), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk("rst_last", 32'(o_last), 32'(0));
    chk("rst_data", 32'(o_data), 32'(0));
    chk("rst_ch", 32'(o_ch), 32'(0));
    i_rst_n = 1'b1;
    tick();
    // abort alone in IDLE does nothing
    i_abort = 1'b1; tick();
    chk("idle_abort_busy", 32'(o_busy), 32'(0));
    // start+abort together: start taken, abort lands next cycle
    i_start = 1'b1; i_gate_len = GW'(5); tick();
    i_start = 1'b0;
    chk("start_abort_busy", 32'(o_busy), 32'(1));
    tick();
    chk("start_abort_idle", 32'(o_busy), 32'(0));
    i_abort = 1'b0; tick();

    run(10, 0, -1, 0, 0, 16'hffff);   // basic
    run(10, 1, -1, 0, 0, 16'hffff);   // ready toggling
    run(0,  0, -1, 0, 0, 16'hffff);   // zero gate
    run(10, 0, -1, 1, 0, 16'hffff);   // counts move after snapshot
    run(10, 0,  4, 0, 0, 16'hffff);   // abort at ch4
    run(10, 0, -1, 0, 0, 16'hffff);   // clean run after abort
    run(10, 0, -1, 0, 1, 16'hffff);   // start during gate ignored
    run(1,  1, -1, 0, 0, 16'hffff);   // single-cycle gate
`ifdef PULSE_SCAN_MASK_EN
    run(10, 0, -1, 0, 0, 16'h0021);
    run(10, 1, -1, 0, 0, 16'h8421);
    run(10, 0, -1, 0, 0, 16'h0000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
